// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and defaults for the RAM port arbiter. The width defaults
//   match the single-port RAM and the SPI slave that share its channel.
//   Contents:
//     DEF_DATA_SIZE / DEF_INST_SIZE / DEF_RD_TIMEOUT  default parameters
//     opcode_t      two-bit command opcode in the MSBs of a command word
//     state_t       arbiter sequence state
//     lock_accepts  which opcodes the owner may send while a sequence is locked
package ram_arb_pkg;

   localparam int DEF_DATA_SIZE  = 8;
   localparam int DEF_INST_SIZE  = 10;
   localparam int DEF_RD_TIMEOUT = 15;

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCK_WR = 2'd1,
      LOCK_RD = 2'd2,
      WAIT_RD = 2'd3
   } state_t;

   // Inside a write lock only write opcodes may pass (re-address or data);
   // inside a read lock only read opcodes. Anything else waits at the input.
   function automatic logic lock_accepts(input state_t s, input opcode_t op);
      case (s)
         LOCK_WR: return (op == OP_WR_ADDR) || (op == OP_WR_DATA);
         LOCK_RD: return (op == OP_RD_ADDR) || (op == OP_RD_DATA);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ram_arb_rd_timer.sv
// ram_arb_rd_timer
//   Cycle counter for the read-wait state of the arbiter.
//   Ports:
//     sclk     in   clock
//     rst      in   synchronous active-high reset
//     start    in   the read-data command is being accepted; count restarts at 0
//     run      in   arbiter is waiting for read data; count advances
//     expired  out  RD_TIMEOUT cycles of waiting have elapsed (valid while run)
module ram_arb_rd_timer #(
   parameter int RD_TIMEOUT = 15
) (
   input  logic sclk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   // The count reads 0 in the first waiting cycle, so the last allowed
   // cycle is RD_TIMEOUT-1; the abort takes effect at the end of it.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RD_TIMEOUT - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge sclk) begin
      if (rst || start) begin
         count_reg <= '0;
      end else if (run && (count_reg != LAST)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign expired = run && (count_reg == LAST);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single-port RAM command/readback channel between two
//   requesters (SPI slave and on-chip host). Two-word sequences
//   (write addr -> write data, read addr -> read data -> readback) are kept
//   atomic; sequences are granted round-robin and readback is routed to the
//   requester that owns the read.
//   Ports:
//     sclk, rst                  clock, synchronous active-high reset
//     reqN_cmd / reqN_valid      command word from requester N
//     reqN_ready                 word accepted this cycle (combinational)
//     reqN_rdata / reqN_rvalid   readback to requester N, rvalid is a 1-cycle pulse
//     ram_cmd / ram_cmd_valid    command word to RAM, one pulse per accepted word
//     ram_rdata / ram_rvalid     readback from RAM
//     owner                      current / last granted requester
//     rd_timeout                 1-cycle pulse when a read is aborted
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_SIZE  = DEF_DATA_SIZE,
   parameter int INST_SIZE  = DEF_INST_SIZE,
   parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic [INST_SIZE-1:0] req0_cmd,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   output logic [DATA_SIZE-1:0] req0_rdata,
   output logic                 req0_rvalid,
   input  logic [INST_SIZE-1:0] req1_cmd,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   output logic [DATA_SIZE-1:0] req1_rdata,
   output logic                 req1_rvalid,
   output logic [INST_SIZE-1:0] ram_cmd,
   output logic                 ram_cmd_valid,
   input  logic [DATA_SIZE-1:0] ram_rdata,
   input  logic                 ram_rvalid,
   output logic                 owner,
   output logic                 rd_timeout
);

   logic [1:0][INST_SIZE-1:0] req_cmd;
   logic [1:0]                req_valid;
   logic [1:0]                req_ready;
   opcode_t                   req_op [2];

   state_t                    state_reg, state_next;
   logic                      owner_reg, owner_next;
   logic                      rr_ptr_reg, rr_ptr_next;
   logic [INST_SIZE-1:0]      ram_cmd_reg, ram_cmd_next;
   logic                      ram_cmd_valid_reg, ram_cmd_valid_next;
   logic [1:0][DATA_SIZE-1:0] rdata_reg, rdata_next;
   logic [1:0]                rvalid_reg, rvalid_next;
   logic                      timeout_reg, timeout_next;

   logic                      winner;
   logic                      sel;
   opcode_t                   sel_op;
   logic                      accept;
   logic                      rd_expired;

   assign req_cmd[0]   = req0_cmd;
   assign req_cmd[1]   = req1_cmd;
   assign req_valid[0] = req0_valid;
   assign req_valid[1] = req1_valid;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign req_op[gi]    = opcode_t'(req_cmd[gi][INST_SIZE-1 -: 2]);
         // Only the selected requester can ever see ready, so a pending
         // word from the other side simply waits at its input.
         assign req_ready[gi] = accept && (sel == 1'(gi));
      end
   endgenerate

   // IDLE grant: a lone requester wins; on a tie the round-robin pointer decides.
   always_comb begin
      if (req_valid[0] && req_valid[1]) begin
         winner = rr_ptr_reg;
      end else begin
         winner = req_valid[1];
      end
   end

   assign sel    = (state_reg == IDLE) ? winner : owner_reg;
   assign sel_op = req_op[sel];

   always_comb begin
      accept = 1'b0;
      case (state_reg)
         IDLE:             accept = |req_valid;
         LOCK_WR, LOCK_RD: accept = req_valid[sel] && lock_accepts(state_reg, sel_op);
         default:          accept = 1'b0;
      endcase
   end

   ram_arb_rd_timer #(
      .RD_TIMEOUT (RD_TIMEOUT)
   ) u_rd_timer (
      .sclk    (sclk),
      .rst     (rst),
      .start   (accept && (sel_op == OP_RD_DATA)),
      .run     (state_reg == WAIT_RD),
      .expired (rd_expired)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_next         = state_reg;
      owner_next         = owner_reg;
      rr_ptr_next        = rr_ptr_reg;
      ram_cmd_next       = ram_cmd_reg;
      ram_cmd_valid_next = 1'b0;
      rdata_next         = rdata_reg;
      rvalid_next        = 2'b00;
      timeout_next       = 1'b0;

      if (accept) begin
         ram_cmd_next       = req_cmd[sel];
         ram_cmd_valid_next = 1'b1;
         owner_next         = sel;
         // Same opcode mapping holds in IDLE and in the locks: an address
         // (re)opens its lock, write data closes the sequence, read data
         // waits for the RAM (a lone read data reads the RAM's current address).
         case (sel_op)
            OP_WR_ADDR: state_next = LOCK_WR;
            OP_RD_ADDR: state_next = LOCK_RD;
            OP_RD_DATA: state_next = WAIT_RD;
            default: begin
               state_next  = IDLE;
               rr_ptr_next = ~sel;
            end
         endcase
      end else if (state_reg == WAIT_RD) begin
         if (ram_rvalid) begin
            rdata_next[owner_reg]  = ram_rdata;
            rvalid_next[owner_reg] = 1'b1;
            state_next             = IDLE;
            rr_ptr_next            = ~owner_reg;
         end else if (rd_expired) begin
            rdata_next[owner_reg]  = '0;
            rvalid_next[owner_reg] = 1'b1;
            timeout_next           = 1'b1;
            state_next             = IDLE;
            rr_ptr_next            = ~owner_reg;
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_reg         <= IDLE;
         owner_reg         <= 1'b0;
         rr_ptr_reg        <= 1'b0;
         ram_cmd_reg       <= '0;
         ram_cmd_valid_reg <= 1'b0;
         rdata_reg         <= '0;
         rvalid_reg        <= 2'b00;
         timeout_reg       <= 1'b0;
      end else begin
         state_reg         <= state_next;
         owner_reg         <= owner_next;
         rr_ptr_reg        <= rr_ptr_next;
         ram_cmd_reg       <= ram_cmd_next;
         ram_cmd_valid_reg <= ram_cmd_valid_next;
         rdata_reg         <= rdata_next;
         rvalid_reg        <= rvalid_next;
         timeout_reg       <= timeout_next;
      end
   end

   assign req0_ready    = req_ready[0];
   assign req1_ready    = req_ready[1];
   assign req0_rdata    = rdata_reg[0];
   assign req1_rdata    = rdata_reg[1];
   assign req0_rvalid   = rvalid_reg[0];
   assign req1_rvalid   = rvalid_reg[1];
   assign ram_cmd       = ram_cmd_reg;
   assign ram_cmd_valid = ram_cmd_valid_reg;
   assign owner         = owner_reg;
   assign rd_timeout    = timeout_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed bench for ram_port_arbiter: write, read, contention and
//   round-robin, lock hold-off, stray readback, read timeout, reset mid-read.
module tb_ram_port_arbiter;

   logic       sclk;
   logic       rst;
   logic [9:0] req0_cmd, req1_cmd;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_rdata, req1_rdata;
   logic       req0_rvalid, req1_rvalid;
   logic [9:0] ram_cmd;
   logic       ram_cmd_valid;
   logic [7:0] ram_rdata;
   logic       ram_rvalid;
   logic       owner;
   logic       rd_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   ram_port_arbiter dut (
      .sclk          (sclk),
      .rst           (rst),
      .req0_cmd      (req0_cmd),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_rdata    (req0_rdata),
      .req0_rvalid   (req0_rvalid),
      .req1_cmd      (req1_cmd),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_rdata    (req1_rdata),
      .req1_rvalid   (req1_rvalid),
      .ram_cmd       (ram_cmd),
      .ram_cmd_valid (ram_cmd_valid),
      .ram_rdata     (ram_rdata),
      .ram_rvalid    (ram_rvalid),
      .owner         (owner),
      .rd_timeout    (rd_timeout)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle 1 time unit past it.
   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic cmd_out(input string tag, input logic [9:0] exp_cmd, input logic exp_owner);
      check({tag, "_ram_cmd"}, 32'(ram_cmd), 32'(exp_cmd));
      check({tag, "_ram_cmd_valid"}, 32'(ram_cmd_valid), 32'd1);
      check({tag, "_owner"}, 32'(owner), 32'(exp_owner));
      $display("[TB] %s ram_cmd=%03h owner=%0d", tag, ram_cmd, owner);
   endtask

   initial begin
      rst = 1'b1;
      req0_cmd = '0; req0_valid = 1'b0;
      req1_cmd = '0; req1_valid = 1'b0;
      ram_rdata = '0; ram_rvalid = 1'b0;
      step();
      step();

      // Reset state
      check("rst_ram_cmd", 32'(ram_cmd), 32'h0);
      check("rst_ram_cmd_valid", 32'(ram_cmd_valid), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_rvalids", 32'({req0_rvalid, req1_rvalid, rd_timeout}), 32'd0);
      check("rst_rdata", 32'({req0_rdata, req1_rdata}), 32'h0);
      rst = 1'b0;

      // Single write by req0
      req0_valid = 1'b1; req0_cmd = 10'h012;
      #1;
      check("wr_ready0", 32'({req0_ready, req1_ready}), 32'b10);
      step();
      cmd_out("wr_addr", 10'h012, 1'b0);
      req0_cmd = 10'h1A5;
      #1;
      check("wr_ready1", 32'(req0_ready), 32'd1);
      step();
      cmd_out("wr_data", 10'h1A5, 1'b0);
      req0_valid = 1'b0;
      step();
      check("wr_idle_valid", 32'(ram_cmd_valid), 32'd0);

      // Read by req1, RAM returns 0xA5
      req1_valid = 1'b1; req1_cmd = 10'h212;
      #1;
      check("rd_ready0", 32'({req0_ready, req1_ready}), 32'b01);
      step();
      cmd_out("rd_addr", 10'h212, 1'b1);
      req1_cmd = 10'h300;
      step();
      cmd_out("rd_data", 10'h300, 1'b1);
      req1_valid = 1'b0;
      step();
      check("rd_wait_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'b00);
      ram_rdata = 8'hA5; ram_rvalid = 1'b1;
      step();
      ram_rvalid = 1'b0;
      check("rd_rdata1", 32'(req1_rdata), 32'hA5);
      check("rd_rvalids", 32'({req0_rvalid, req1_rvalid}), 32'b01);
      $display("[TB] read req1_rdata=%02h", req1_rdata);
      step();
      check("rd_rvalid_pulse", 32'(req1_rvalid), 32'd0);

      // Contention: rr pointer now favours req0
      req0_valid = 1'b1; req0_cmd = 10'h020;
      req1_valid = 1'b1; req1_cmd = 10'h230;
      #1;
      check("ct_tie1", 32'({req0_ready, req1_ready}), 32'b10);
      step();
      cmd_out("ct_r0_addr", 10'h020, 1'b0);
      req0_cmd = 10'h155;
      #1;
      check("ct_locked", 32'({req0_ready, req1_ready}), 32'b10);
      step();
      cmd_out("ct_r0_data", 10'h155, 1'b0);
      req0_cmd = 10'h021;
      #1;
      check("ct_tie2", 32'({req0_ready, req1_ready}), 32'b01);
      step();
      cmd_out("ct_r1_addr", 10'h230, 1'b1);
      req1_cmd = 10'h300;
      #1;
      check("ct_rdlock", 32'({req0_ready, req1_ready}), 32'b01);
      step();
      cmd_out("ct_r1_data", 10'h300, 1'b1);
      req1_valid = 1'b0;
      #1;
      check("ct_waitrd_ready", 32'({req0_ready, req1_ready}), 32'b00);
      ram_rdata = 8'h77; ram_rvalid = 1'b1;
      step();
      ram_rvalid = 1'b0;
      check("ct_rdata1", 32'({req1_rvalid, req1_rdata}), 32'h177);
      req1_valid = 1'b1; req1_cmd = 10'h212;
      #1;
      check("ct_tie3", 32'({req0_ready, req1_ready}), 32'b10);
      step();
      cmd_out("ct_r0_again", 10'h021, 1'b0);
      check("ct_rvalid_pulse", 32'(req1_rvalid), 32'd0);

      // Lock hold-off: req0 owns a write lock, then goes quiet
      req0_valid = 1'b0;
      req1_cmd = 10'h199;
      #1;
      check("lk_ready1_a", 32'(req1_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("lk_hold_valid", 32'(ram_cmd_valid), 32'd0);
         check("lk_hold_ready", 32'({req0_ready, req1_ready}), 32'b00);
      end
      req0_valid = 1'b1; req0_cmd = 10'h201;
      #1;
      check("lk_wrong_op", 32'({req0_ready, req1_ready}), 32'b00);
      req0_cmd = 10'h166;
      #1;
      check("lk_close", 32'({req0_ready, req1_ready}), 32'b10);
      step();
      cmd_out("lk_r0_data", 10'h166, 1'b0);
      req0_valid = 1'b0;
      #1;
      check("lk_release", 32'(req1_ready), 32'd1);
      step();
      cmd_out("lk_r1_data", 10'h199, 1'b1);
      req1_valid = 1'b0;

      // Stray RAM readback in IDLE is ignored
      ram_rdata = 8'h3C; ram_rvalid = 1'b1;
      step();
      ram_rvalid = 1'b0;
      check("stray_rvalid", 32'({req0_rvalid, req1_rvalid, rd_timeout}), 32'd0);
      check("stray_rdata1", 32'(req1_rdata), 32'h77);

      // Read timeout for req0
      req0_valid = 1'b1; req0_cmd = 10'h205;
      step();
      cmd_out("to_addr", 10'h205, 1'b0);
      req0_cmd = 10'h300;
      ram_rdata = 8'hEE;
      step();
      cmd_out("to_data", 10'h300, 1'b0);
      req0_valid = 1'b0;
      for (int i = 1; i < 15; i++) begin
         step();
         check("to_early", 32'({req0_rvalid, rd_timeout}), 32'b00);
      end
      step();
      check("to_fire", 32'({req0_rvalid, rd_timeout}), 32'b11);
      check("to_rdata", 32'(req0_rdata), 32'h0);
      $display("[TB] timeout rd_timeout=%0d req0_rdata=%02h", rd_timeout, req0_rdata);
      step();
      check("to_pulse", 32'({req0_rvalid, rd_timeout}), 32'b00);

      // Reset during a req1 read, then a late RAM reply
      req1_valid = 1'b1; req1_cmd = 10'h207;
      step();
      req1_cmd = 10'h300;
      step();
      cmd_out("rr_data", 10'h300, 1'b1);
      req1_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ram_rdata = 8'h5A; ram_rvalid = 1'b1;
      step();
      ram_rvalid = 1'b0;
      check("rr_rvalid", 32'({req0_rvalid, req1_rvalid, rd_timeout}), 32'd0);
      check("rr_ram_cmd", 32'({ram_cmd_valid, ram_cmd}), 32'h0);
      check("rr_owner", 32'(owner), 32'd0);
      check("rr_rdata", 32'({req0_rdata, req1_rdata}), 32'h0);
      req0_valid = 1'b1; req0_cmd = 10'h011;
      req1_valid = 1'b1; req1_cmd = 10'h011;
      #1;
      check("rr_tie_after_rst", 32'({req0_ready, req1_ready}), 32'b10);
      $display("[TB] reset mid-read owner=%0d req1_rvalid=%0d", owner, req1_rvalid);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
